// File: rtl/npc_mem_pkg.sv
// Shared definitions for the NPC memory-port arbitration logic.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_MASK_W = 8;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant: a tie goes to whichever requester was not served last.
module mem_rr_arbiter
  import npc_mem_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant, bit REQ_IFU / bit REQ_LSU
  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      if (last_grant == REQ_LSU) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else if (ifu_valid) begin
      grant = 2'b01;
    end else if (lsu_valid) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IFU and LSU, one transaction at a time,
// holding the address for MEM_LAT cycles before sampling read data or firing the write.
module mem_port_arbiter
  import npc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MASK_W  = DEF_MASK_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  mem_state_e        state_r, state_s;
  logic [3:0]        cnt_r;
  logic              last_grant_r;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wen_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        grant_s;
  logic              req_fire_s;
  logic              last_wait_s;
  logic              resp_fire_s;
  logic              in_wait_s;

  mem_rr_arbiter u_rr (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and request-side handshake decode
  always_comb begin
    state_s       = state_r;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    req_fire_s    = 1'b0;
    last_wait_s   = 1'b0;
    resp_fire_s   = 1'b0;
    case (state_r)
      IDLE: begin
        ifu_req_ready = grant_s[REQ_IFU];
        lsu_req_ready = grant_s[REQ_LSU];
        req_fire_s    = (ifu_req_valid && grant_s[REQ_IFU]) ||
                        (lsu_req_valid && grant_s[REQ_LSU]);
        if (req_fire_s) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          last_wait_s = 1'b1;
          state_s     = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        resp_fire_s = (owner_r == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready;
        if (resp_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Transaction latch, latency counter, response capture and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= 4'd0;
      last_grant_r <= REQ_LSU;
      owner_r      <= REQ_IFU;
      addr_r       <= {ADDR_W{1'b0}};
      wen_r        <= 1'b0;
      wdata_r      <= {DATA_W{1'b0}};
      wmask_r      <= {MASK_W{1'b0}};
      rdata_r      <= {DATA_W{1'b0}};
    end else if (req_fire_s) begin
      cnt_r <= CNT_LOAD;
      if (grant_s[REQ_LSU]) begin
        owner_r <= REQ_LSU;
        addr_r  <= lsu_addr;
        wen_r   <= lsu_wen;
        wdata_r <= lsu_wdata;
        wmask_r <= lsu_wmask;
      end else begin
        owner_r <= REQ_IFU;
        addr_r  <= ifu_addr;
        wen_r   <= 1'b0;
        wdata_r <= {DATA_W{1'b0}};
        wmask_r <= {MASK_W{1'b0}};
      end
    end else if (last_wait_s) begin
      rdata_r <= wen_r ? {DATA_W{1'b0}} : mem_rdata;
    end else if (in_wait_s) begin
      cnt_r <= cnt_r - 4'd1;
    end else if (resp_fire_s) begin
      last_grant_r <= owner_r;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Memory-side outputs decode only registered state, so reset drops them at once
  assign in_wait_s      = (state_r == WAIT);
  assign mem_raddr      = in_wait_s ? addr_r  : {ADDR_W{1'b0}};
  assign mem_waddr      = in_wait_s ? addr_r  : {ADDR_W{1'b0}};
  assign mem_wdata      = in_wait_s ? wdata_r : {DATA_W{1'b0}};
  assign mem_wmask      = in_wait_s ? wmask_r : {MASK_W{1'b0}};
  assign mem_wen        = in_wait_s && (cnt_r == 4'd0) && wen_r;

  assign ifu_resp_valid = (state_r == RESP) && (owner_r == REQ_IFU);
  assign lsu_resp_valid = (state_r == RESP) && (owner_r == REQ_LSU);
  assign ifu_rdata      = ifu_resp_valid ? rdata_r : {DATA_W{1'b0}};
  assign lsu_rdata      = lsu_resp_valid ? rdata_r : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a MEM_LAT=3 arbiter driven by a vector table and hand sequences,
// plus a MEM_LAT=1 instance for the single-cycle fetch timing.
module tb_mem_port_arbiter;

  localparam logic [63:0] A_I = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A_L = 64'h0000_0000_8000_1000;
  localparam logic [63:0] D1  = 64'h0000_0413_0000_0297;
  localparam logic [63:0] D2  = 64'h0000_0000_CAFE_F00D;
  localparam logic [63:0] D3  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] G   = 64'h1111_2222_3333_4444;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
  logic [63:0] ifu_addr = 64'd0, ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0;
  logic [63:0] lsu_addr = 64'd0, lsu_wdata = 64'd0, lsu_rdata;
  logic [7:0]  lsu_wmask = 8'd0, mem_wmask;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata = 64'd0;
  logic        mem_wen;

  logic        f_ifu_req_valid = 1'b0, f_ifu_req_ready, f_ifu_resp_valid, f_ifu_resp_ready = 1'b0;
  logic [63:0] f_ifu_addr = 64'd0, f_ifu_rdata, f_lsu_rdata;
  logic        f_lsu_req_ready, f_lsu_resp_valid, f_mem_wen;
  logic [63:0] f_mem_raddr, f_mem_waddr, f_mem_wdata, f_mem_rdata = 64'd0;
  logic [7:0]  f_mem_wmask;

  mem_port_arbiter #(.MEM_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(f_ifu_req_valid), .ifu_req_ready(f_ifu_req_ready), .ifu_addr(f_ifu_addr),
    .ifu_resp_valid(f_ifu_resp_valid), .ifu_resp_ready(f_ifu_resp_ready), .ifu_rdata(f_ifu_rdata),
    .lsu_req_valid(1'b0), .lsu_req_ready(f_lsu_req_ready), .lsu_addr(64'd0),
    .lsu_wen(1'b0), .lsu_wdata(64'd0), .lsu_wmask(8'd0),
    .lsu_resp_valid(f_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(f_lsu_rdata),
    .mem_raddr(f_mem_raddr), .mem_waddr(f_mem_waddr), .mem_wdata(f_mem_wdata),
    .mem_wmask(f_mem_wmask), .mem_wen(f_mem_wen), .mem_rdata(f_mem_rdata)
  );

  typedef struct {
    logic        iv, lv, irr, lrr;
    logic [63:0] mrd;
    logic        e_ir, e_lr, e_irv, e_lrv;
    logic [63:0] e_ird, e_lrd, e_raddr;
  } vec_t;

  vec_t tbl [11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, lv, input logic [63:0] mrd,
                              input logic ir, lr, irv, lrv,
                              input logic [63:0] ird, lrd, raddr);
    vec_t v;
    v.iv = iv; v.lv = lv; v.irr = 1'b1; v.lrr = 1'b1; v.mrd = mrd;
    v.e_ir = ir; v.e_lr = lr; v.e_irv = irv; v.e_lrv = lrv;
    v.e_ird = ird; v.e_lrd = lrd; v.e_raddr = raddr;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Both requesters valid every cycle: IFU first (history starts at LSU), then LSU, then idle
    tbl[0]  = mk(1'b1, 1'b1, G,  1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    tbl[1]  = mk(1'b1, 1'b1, G,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, A_I);
    tbl[2]  = mk(1'b1, 1'b1, G,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, A_I);
    tbl[3]  = mk(1'b1, 1'b1, D1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, A_I);
    tbl[4]  = mk(1'b1, 1'b1, G,  1'b0, 1'b0, 1'b1, 1'b0, D1,    64'd0, 64'd0);
    tbl[5]  = mk(1'b1, 1'b1, G,  1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    tbl[6]  = mk(1'b1, 1'b1, G,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, A_L);
    tbl[7]  = mk(1'b1, 1'b1, G,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, A_L);
    tbl[8]  = mk(1'b1, 1'b1, D2, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, A_L);
    tbl[9]  = mk(1'b1, 1'b1, G,  1'b0, 1'b0, 1'b0, 1'b1, 64'd0, D2,    64'd0);
    tbl[10] = mk(1'b0, 1'b0, G,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ifu_ready", ifu_req_ready, 64'd0);
    check("rst_lsu_ready", lsu_req_ready, 64'd0);
    check("rst_ifu_resp_valid", ifu_resp_valid, 64'd0);
    check("rst_lsu_resp_valid", lsu_resp_valid, 64'd0);
    check("rst_mem_wen", mem_wen, 64'd0);
    check("rst_mem_raddr", mem_raddr, 64'd0);

    // MEM_LAT=1 fetch: accept in cycle 0, address in cycle 1, response in cycle 2
    @(negedge clk);
    f_ifu_req_valid = 1'b1; f_ifu_addr = A_I; f_ifu_resp_ready = 1'b1; f_mem_rdata = G;
    #1 check("l1_ifu_ready_c0", f_ifu_req_ready, 64'd1);
    @(negedge clk);
    f_ifu_req_valid = 1'b0; f_mem_rdata = D1;
    #1 check("l1_mem_raddr_c1", f_mem_raddr, A_I);
    check("l1_resp_valid_c1", f_ifu_resp_valid, 64'd0);
    @(negedge clk);
    f_mem_rdata = G;
    #1 check("l1_resp_valid_c2", f_ifu_resp_valid, 64'd1);
    check("l1_rdata_c2", f_ifu_rdata, D1);

    ifu_addr = A_I; lsu_addr = A_L; lsu_wen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ifu_req_valid = tbl[i].iv; lsu_req_valid = tbl[i].lv;
      ifu_resp_ready = tbl[i].irr; lsu_resp_ready = tbl[i].lrr; mem_rdata = tbl[i].mrd;
      #1;
      check($sformatf("v%0d_ifu_ready", i), ifu_req_ready, tbl[i].e_ir);
      check($sformatf("v%0d_lsu_ready", i), lsu_req_ready, tbl[i].e_lr);
      check($sformatf("v%0d_ifu_resp_valid", i), ifu_resp_valid, tbl[i].e_irv);
      check($sformatf("v%0d_lsu_resp_valid", i), lsu_resp_valid, tbl[i].e_lrv);
      check($sformatf("v%0d_ifu_rdata", i), ifu_rdata, tbl[i].e_ird);
      check($sformatf("v%0d_lsu_rdata", i), lsu_rdata, tbl[i].e_lrd);
      check($sformatf("v%0d_mem_raddr", i), mem_raddr, tbl[i].e_raddr);
      check($sformatf("v%0d_mem_wen", i), mem_wen, 64'd0);
    end

    // LSU store: write strobe only in the third WAIT cycle, with latched values
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = A_L;
    lsu_wdata = 64'h0000_0000_DEAD_BEEF; lsu_wmask = 8'h0F; lsu_resp_ready = 1'b1;
    #1 check("st_lsu_ready", lsu_req_ready, 64'd1);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      lsu_req_valid = 1'b0; lsu_wdata = G; lsu_wmask = 8'hFF;
      #1;
      check($sformatf("st_w%0d_mem_wen", w), mem_wen, (w == 2) ? 64'd1 : 64'd0);
      check($sformatf("st_w%0d_waddr", w), mem_waddr, A_L);
      check($sformatf("st_w%0d_wdata", w), mem_wdata, 64'h0000_0000_DEAD_BEEF);
      check($sformatf("st_w%0d_wmask", w), mem_wmask, 64'h0F);
    end
    @(negedge clk);
    #1 check("st_resp_valid", lsu_resp_valid, 64'd1);
    check("st_rdata", lsu_rdata, 64'd0);
    check("st_resp_mem_wen", mem_wen, 64'd0);
    check("st_resp_waddr", mem_waddr, 64'd0);

    // LSU load; IFU arrives mid-WAIT and is held off through a backpressured response
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h0000_0000_8000_2000;
    lsu_resp_ready = 1'b0; mem_rdata = G;
    #1 check("ld_lsu_ready", lsu_req_ready, 64'd1);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      lsu_req_valid = 1'b0; ifu_req_valid = (w >= 1); ifu_addr = A_I + 64'd4;
      mem_rdata = (w == 2) ? D3 : G;
      #1;
      check($sformatf("ld_w%0d_ifu_ready", w), ifu_req_ready, 64'd0);
      check($sformatf("ld_w%0d_raddr", w), mem_raddr, 64'h0000_0000_8000_2000);
    end
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      mem_rdata = G;
      #1;
      check($sformatf("bp%0d_lsu_resp_valid", b), lsu_resp_valid, 64'd1);
      check($sformatf("bp%0d_lsu_rdata", b), lsu_rdata, D3);
      check($sformatf("bp%0d_ifu_ready", b), ifu_req_ready, 64'd0);
      check($sformatf("bp%0d_mem_wen", b), mem_wen, 64'd0);
      check($sformatf("bp%0d_ifu_resp_valid", b), ifu_resp_valid, 64'd0);
    end
    @(negedge clk);
    lsu_resp_ready = 1'b1;
    #1 check("bp_release_valid", lsu_resp_valid, 64'd1);
    check("bp_release_rdata", lsu_rdata, D3);
    @(negedge clk);
    #1 check("ifu_after_resp_ready", ifu_req_ready, 64'd1);

    // Reset during WAIT clears the transaction immediately
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1 check("ifu_wait_raddr", mem_raddr, A_I + 64'd4);
    #1 rst_n = 1'b0;
    #1 check("rstw_mem_raddr", mem_raddr, 64'd0);
    check("rstw_ifu_resp_valid", ifu_resp_valid, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the final WAIT cycle of a store drops mem_wen asynchronously
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h0000_0000_8000_3000;
    lsu_wdata = 64'h55; lsu_wmask = 8'hFF;
    #1 check("st2_lsu_ready", lsu_req_ready, 64'd1);
    repeat (3) @(negedge clk);
    lsu_req_valid = 1'b0;
    #1 check("st2_last_wait_wen", mem_wen, 64'd1);
    #1 rst_n = 1'b0;
    #1 check("st2_rst_mem_wen", mem_wen, 64'd0);
    check("st2_rst_waddr", mem_waddr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
    #1 check("post_rst_ifu_grant", ifu_req_ready, 64'd1);
    check("post_rst_lsu_grant", lsu_req_ready, 64'd0);
    check("post_rst_resp_valid", lsu_resp_valid, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single DPI-backed memory port (pmem_read/pmem_write wrapper) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one transaction at a time through a valid/ready request channel per requester. Drives the memory port for a configurable emulated latency, then returns the result through a per-requester valid/ready response channel.
- Sits between the IFU/LSU and the memory wrapper inside the NPC top.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MASK_W, 8, byte-write-mask width (DATA_W/8)
- MEM_LAT, 1, cycles the memory address is held before data is sampled or the write fires; legal range 1..15

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  MASK_W  store byte mask
- lsu_resp_valid  out  1  load data / store done
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  DATA_W  load data; 0 for stores
- mem_raddr  out  ADDR_W  to memory Raddr
- mem_waddr  out  ADDR_W  to memory Waddr
- mem_wdata  out  DATA_W  to memory Wdata
- mem_wmask  out  MASK_W  to memory Wmask
- mem_wen  out  1  to memory Write_en
- mem_rdata  in  DATA_W  from memory Rdata

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, counter = 0, last_grant = LSU
  - all *_ready and *_resp_valid = 0
  - mem_wen = 0
  - mem_* address/data/mask outputs = 0
  - rdata outputs = 0
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant computed combinationally from the two req_valid inputs and last_grant.
  - Only one requester valid → that requester is granted.
  - Both valid → the requester that is not last_grant is granted (round-robin).
  - Granted requester's req_ready = 1; the other = 0. No valid → both ready = 0.
  - On handshake (valid & ready): latch owner id, addr, wen (IFU is always 0), wdata, wmask; load counter = MEM_LAT-1; go to WAIT.
- WAIT:
  - mem_raddr = mem_waddr = latched addr; mem_wdata/mem_wmask = latched values.
  - counter decrements each cycle.
  - When counter == 0:
    - capture mem_rdata into the response register (capture 0 if write);
    - assert mem_wen for exactly this one cycle if latched wen = 1;
    - go to RESP.
  - Total WAIT cycles = MEM_LAT.
- RESP:
  - Owner's resp_valid = 1; its rdata is held stable. The other requester's resp_valid = 0.
  - mem_wen = 0. mem_* outputs return to 0.
  - On resp_ready: go to IDLE and set last_grant = owner.
  - A response is never dropped or changed while resp_valid = 1.
- Timing:
  - Minimum occupancy per transaction = 1 (accept) + MEM_LAT + 1 (resp) cycles.
  - A request presented during WAIT/RESP sees req_ready = 0 and must hold its request.
- Outside WAIT:
  - mem_wen = 0, mem_raddr = 0, mem_waddr = 0, mem_wdata = 0, mem_wmask = 0.
  - mem_wen is decoded from registered state only, never from inputs, so no combinational input→mem_wen path exists.
- Simultaneous events: both requesters valid in the same IDLE cycle → resolved by last_grant. The loser is guaranteed the next grant (no starvation).
- Reset mid-operation: state, counter and response are cleared immediately. mem_wen drops asynchronously. A pending store that has not reached its final WAIT cycle is not written.
- Addresses pass through unmodified; alignment is the requester's responsibility.

Decomposition:
- Shared package npc_mem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - requester id constants REQ_IFU = 0, REQ_LSU = 1
  - default width constants
- Sub-module mem_rr_arbiter: 2-way round-robin grant.
  - Inputs: two valids, last_grant.
  - Output: one-hot grant.
  - Purely combinational; reused later for the AXI-side arbiter.

Test Plan:
- Reset: hold rst_n = 0 then release → all ready/resp_valid/mem_wen = 0 and mem_raddr = 0. Asserting rst_n = 0 during WAIT clears state the same cycle.
- IFU fetch, MEM_LAT = 1, ifu_addr = 0x80000000, mem_rdata = 0x00000413_00000297:
  - ifu_req_ready = 1 in cycle 0;
  - mem_raddr = 0x80000000 in cycle 1;
  - ifu_resp_valid = 1 with that data in cycle 2.
- LSU store, MEM_LAT = 3, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F:
  - mem_wen high for exactly one cycle (the 3rd WAIT cycle) with those values;
  - lsu_resp_valid = 1 and lsu_rdata = 0 the next cycle.
- Both valid every cycle from reset, both resp_ready = 1 → grants alternate IFU, LSU, IFU, LSU.
- Backpressure: hold lsu_resp_ready = 0 for 5 cycles during RESP → lsu_resp_valid and lsu_rdata stay constant; ifu_req_ready stays 0; mem_wen stays 0.
- IFU request arrives mid-WAIT of an LSU load → ifu_req_ready = 0 until RESP completes, then IFU is granted in the next IDLE cycle.
